// File: rtl/data_sram_bridge_pkg.sv
// Shared types for the MEM-stage data SRAM bridge: FSM encoding, access
// size codes and the latched bus request payload.
package data_sram_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } bridge_state_e;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] sel;
    logic [SIZE_W-1:0] size;
    logic              wr;
  } bus_req_t;

  // kseg0/kseg1 occupy 0x8000_0000-0xBFFF_FFFF
  function automatic logic is_kseg01(input logic [ADDR_W-1:0] vaddr);
    return vaddr[ADDR_W-1 -: 2] == 2'b10;
  endfunction

endpackage

// File: rtl/data_sram_bridge_addr_mmap.sv
// Fixed virtual-to-physical mapping: strips the segment bits of kseg0/kseg1.
module addr_mmap
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned KSEG_MAP = 1
) (
  input  logic [ADDR_W-1:0] vaddr_i,
  output logic [ADDR_W-1:0] paddr_o
);

  always_comb begin
    paddr_o = vaddr_i;
    if ((KSEG_MAP != 0) && is_kseg01(vaddr_i)) begin
      paddr_o = {3'b000, vaddr_i[28:0]};
    end
  end

endmodule

// File: rtl/data_sram_bridge.sv
// MEM-stage to SRAM-like data bus bridge: one outstanding request, holds the
// pipeline while the access is in flight, and supports flush cancellation.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned KSEG_MAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [STRB_W-1:0] mem_sel,
  input  logic [SIZE_W-1:0] mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_except,
  input  logic              flush,
  input  logic              pipe_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [SIZE_W-1:0] data_size,
  output logic [STRB_W-1:0] data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  bridge_state_e     state_q, state_d;
  bus_req_t          req_q, req_d;
  logic              cancel_q, cancel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] paddr;
  logic              go;
  logic              complete;

  addr_mmap #(
    .KSEG_MAP(KSEG_MAP)
  ) u_addr_mmap (
    .vaddr_i(mem_addr),
    .paddr_o(paddr)
  );

  assign go        = mem_en & ~mem_except & ~flush;
  assign mem_rdata = rdata_q;

  // Next-state, latch and bus-output logic
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cancel_d   = cancel_q;
    rdata_d    = rdata_q;
    complete   = 1'b0;
    stall      = 1'b0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = '0;
    data_wstrb = '0;
    data_addr  = '0;
    data_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          stall         = 1'b1;
          state_d       = S_ADDR;
          cancel_d      = 1'b0;
          req_d.addr    = paddr;
          req_d.wdata   = mem_wdata;
          req_d.sel     = mem_sel;
          req_d.size    = mem_size;
          req_d.wr      = |mem_sel;
        end
      end
      S_ADDR: begin
        stall      = 1'b1;
        data_req   = 1'b1;
        data_wr    = req_q.wr;
        data_size  = req_q.size;
        data_wstrb = req_q.wr ? req_q.sel : '0;
        data_addr  = req_q.addr;
        data_wdata = req_q.wdata;
        if (flush) cancel_d = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) complete = 1'b1;
          else              state_d  = S_DATA;
        end
      end
      S_DATA: begin
        stall = 1'b1;
        if (flush)        cancel_d = 1'b1;
        if (data_data_ok) complete = 1'b1;
      end
      S_DONE: begin
        if (flush || !pipe_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flushed access still drains on the bus but never reaches DONE
    if (complete) begin
      if (cancel_q || flush) begin
        state_d  = S_IDLE;
        cancel_d = 1'b0;
      end else begin
        state_d = S_DONE;
        if (!req_q.wr) rdata_d = data_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      cancel_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed scoreboard bench for data_sram_bridge.
module tb_data_sram_bridge;
  import data_sram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_sel;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_except;
  logic        flush;
  logic        pipe_stall;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic        wr;
    logic [31:0] wdata;
  } exp_req_t;

  exp_req_t    req_sb[$];
  logic [31:0] rd_sb[$];
  exp_req_t    exp_cur;
  logic [31:0] model_rdata;
  int          checks   = 0;
  int          failures = 0;

  data_sram_bridge #(.KSEG_MAP(1)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_sel(mem_sel), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_except(mem_except), .flush(flush),
    .pipe_stall(pipe_stall), .mem_rdata(mem_rdata), .stall(stall), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] phys(input logic [31:0] v);
    if (v >= 32'h8000_0000 && v <= 32'hBFFF_FFFF) return v & 32'h1FFF_FFFF;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [3:0] sel,
                       input logic [1:0] size, input logic [31:0] wdata);
    exp_req_t e;
    mem_en    = 1'b1;
    mem_addr  = addr;
    mem_sel   = sel;
    mem_size  = size;
    mem_wdata = wdata;
    e.addr  = phys(addr);
    e.size  = size;
    e.strb  = sel;
    e.wr    = (sel != 4'b0000);
    e.wdata = wdata;
    req_sb.push_back(e);
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_req"},   32'(data_req),   32'd1);
    check({tag, "_addr"},  data_addr,       exp_cur.addr);
    check({tag, "_size"},  32'(data_size),  32'(exp_cur.size));
    check({tag, "_wstrb"}, 32'(data_wstrb), 32'(exp_cur.strb));
    check({tag, "_wr"},    32'(data_wr),    32'(exp_cur.wr));
    check({tag, "_wdata"}, data_wdata,      exp_cur.wdata);
  endtask

  task automatic check_req(input string tag);
    checks++;
    assert (req_sb.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (req_sb.size() != 0) begin
      exp_cur = req_sb.pop_front();
      check_hold(tag);
    end
  endtask

  task automatic check_rdata(input string tag);
    checks++;
    assert (rd_sb.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (rd_sb.size() != 0) check(tag, mem_rdata, rd_sb.pop_front());
  endtask

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_sel = '0; mem_size = '0; mem_addr = '0;
    mem_wdata = '0; mem_except = 1'b0; flush = 1'b0; pipe_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; model_rdata = '0;

    // reset state
    tick(); tick(); rst = 1'b0; settle();
    check("rst_req",   32'(data_req), 32'd0);
    check("rst_stall", 32'(stall),    32'd0);
    check("rst_rdata", mem_rdata,     32'd0);
    check("rst_addr",  data_addr,     32'd0);

    // LW kseg0, addr_ok at t+1, data_ok at t+3
    tick(); issue(32'h8000_0010, 4'b0000, SIZE_WORD, 32'h0); settle();
    check("lw_stall_t0", 32'(stall), 32'd1);
    check("lw_noreq_t0", 32'(data_req), 32'd0);
    tick(); data_addr_ok = 1'b1; settle();
    check_req("lw");
    check("lw_stall_t1", 32'(stall), 32'd1);
    tick(); data_addr_ok = 1'b0; settle();
    check("lw_req_t2",   32'(data_req), 32'd0);
    check("lw_addr_t2",  data_addr,     32'd0);
    check("lw_stall_t2", 32'(stall),    32'd1);
    tick(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    model_rdata = 32'hDEAD_BEEF; rd_sb.push_back(model_rdata); settle();
    check("lw_stall_t3", 32'(stall), 32'd1);
    tick(); data_data_ok = 1'b0; mem_en = 1'b0; settle();
    check("lw_stall_t4", 32'(stall), 32'd0);
    check_rdata("lw_rdata");
    tick(); settle();
    check("lw_idle_req", 32'(data_req), 32'd0);

    // SB kseg1 with addr_ok delayed 3 cycles
    issue(32'hBFC0_0002, 4'b0100, SIZE_BYTE, 32'hABAB_ABAB); settle();
    check("sb_stall_t0", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); data_addr_ok = (i == 3); settle();
      if (i == 0) check_req("sb");
      else        check_hold("sb_hold");
      check("sb_stall", 32'(stall), 32'd1);
    end
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    rd_sb.push_back(model_rdata); settle();
    check("sb_data_req", 32'(data_req), 32'd0);
    tick(); data_data_ok = 1'b0; mem_en = 1'b0; settle();
    check("sb_done_stall", 32'(stall), 32'd0);
    check_rdata("sb_rdata_kept");

    // exception and flush suppress the access in IDLE
    tick(); mem_en = 1'b1; mem_except = 1'b1; mem_addr = 32'h0000_0001; mem_sel = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("exc_req",   32'(data_req), 32'd0);
      check("exc_stall", 32'(stall),    32'd0);
      tick();
    end
    mem_except = 1'b0; flush = 1'b1; settle();
    check("flidle_stall", 32'(stall), 32'd0);
    tick(); flush = 1'b0; mem_en = 1'b0; settle();
    check("flidle_req", 32'(data_req), 32'd0);

    // flush while in DATA: drain the response, no update, no DONE
    tick(); issue(32'h0000_1000, 4'b0000, SIZE_WORD, 32'h0); settle();
    tick(); data_addr_ok = 1'b1; settle();
    check_req("fl");
    tick(); data_addr_ok = 1'b0; flush = 1'b1; mem_en = 1'b0; settle();
    check("fl_stall_data", 32'(stall), 32'd1);
    tick(); flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678; settle();
    check("fl_stall_dok", 32'(stall), 32'd1);
    tick(); data_data_ok = 1'b0; issue(32'h0000_0200, 4'b0000, SIZE_WORD, 32'h0); settle();
    check("fl_idle_go",  32'(stall),    32'd1);
    check("fl_idle_req", 32'(data_req), 32'd0);
    check("fl_rdata",    mem_rdata,     model_rdata);

    // min-latency load, then DONE held by pipe_stall
    tick(); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    pipe_stall = 1'b1; model_rdata = 32'hCAFE_F00D; rd_sb.push_back(model_rdata); settle();
    check_req("ps");
    tick(); data_addr_ok = 1'b0; data_data_ok = 1'b0; settle();
    check("ps_stall_t2", 32'(stall), 32'd0);
    check_rdata("ps_rdata");
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check("ps_done_req",   32'(data_req), 32'd0);
      check("ps_done_stall", 32'(stall),    32'd0);
    end
    tick(); pipe_stall = 1'b0; settle();
    check("ps_release_stall", 32'(stall), 32'd0);

    // reset mid-ADDR abandons the request
    tick(); issue(32'hA000_0040, 4'b0000, SIZE_WORD, 32'h0); settle();
    check("rm_idle_go", 32'(stall), 32'd1);
    tick(); rst = 1'b1; settle();
    check_req("rm");
    tick(); rst = 1'b0; mem_en = 1'b0; settle();
    model_rdata = '0;
    check("rm_req",   32'(data_req),   32'd0);
    check("rm_stall", 32'(stall),      32'd0);
    check("rm_rdata", mem_rdata,       32'd0);
    check("rm_addr",  data_addr,       32'd0);
    check("rm_wr",    32'(data_wr),    32'd0);
    check("rm_size",  32'(data_size),  32'd0);
    check("rm_wstrb", 32'(data_wstrb), 32'd0);
    check("rm_wdata", data_wdata,      32'd0);

    // following LW proceeds normally
    tick(); issue(32'h9000_0004, 4'b0000, SIZE_WORD, 32'h0); settle();
    check("pr_stall_t0", 32'(stall), 32'd1);
    tick(); data_addr_ok = 1'b1; settle();
    check_req("pr");
    tick(); data_addr_ok = 1'b0; settle();
    check("pr_stall_t2", 32'(stall), 32'd1);
    tick(); data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    model_rdata = 32'h0BAD_F00D; rd_sb.push_back(model_rdata); settle();
    tick(); data_data_ok = 1'b0; mem_en = 1'b0; settle();
    check("pr_done_stall", 32'(stall), 32'd0);
    check_rdata("pr_rdata");
    tick(); settle();
    check("pr_idle_req", 32'(data_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
